volatility_scheduler: RTL and testbench

Front-end controller for the per-stock volatility circular-buffer datapath. Accepts best-bid/best-ask updates from one request channel per stock, arbitrates round-robin into the single-write-per-cycle datapath, and owns each stock's write pointer and fill count. Forwards a result tag (stock id, warm flag) aligned with the datapath's `o_data_valid` for the downstream spread/reference-price stage.

---
 rtl/volatility_scheduler_pkg.sv | 20 ++
 rtl/volatility_scheduler_rr_arbiter.sv | 48 ++++
 rtl/volatility_scheduler.sv | 151 +++++++++++++++
 tb/tb_volatility_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/volatility_scheduler_pkg.sv
// Shared sizing, types and result-tag layout for the volatility window front-end.
package vol_pkg;

  localparam int NUM_STOCKS  = 4;
  localparam int BUFFER_SIZE = 20;
  localparam int DATA_WIDTH  = 32;

  localparam int ID_W   = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int ADDR_W = $clog2(NUM_STOCKS * BUFFER_SIZE);

  typedef logic [ID_W-1:0]   stock_id_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic      valid;
    stock_id_t stock_id;
    logic      warm;
  } tag_t;

endpackage

// File: rtl/volatility_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts at the requester after the last winner.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_grant_valid
);

  logic [ID_W-1:0] prio_q;

  function automatic logic [ID_W-1:0] next_prio(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    int  idx;
    logic found;
    o_grant       = '0;
    o_grant_id    = '0;
    o_grant_valid = 1'b0;
    idx           = 0;
    found         = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(prio_q) + k) % NUM_REQ;
      if (i_enable && !found && i_req[idx]) begin
        o_grant[idx]  = 1'b1;
        o_grant_id    = ID_W'(idx);
        o_grant_valid = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      prio_q <= '0;
    end else if (o_grant_valid) begin
      prio_q <= next_prio(o_grant_id);
    end
  end

endmodule

// File: rtl/volatility_scheduler.sv
// Per-stock update arbitration, window pointer/fill bookkeeping and datapath-aligned result tags.
module volatility_scheduler #(
  parameter int DATA_WIDTH  = vol_pkg::DATA_WIDTH,
  parameter int BUFFER_SIZE = vol_pkg::BUFFER_SIZE,
  parameter int NUM_STOCKS  = vol_pkg::NUM_STOCKS
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset_n,
  input  logic [NUM_STOCKS-1:0]                  i_req_valid,
  input  logic [NUM_STOCKS-1:0][DATA_WIDTH-1:0]  i_req_ask,
  input  logic [NUM_STOCKS-1:0][DATA_WIDTH-1:0]  i_req_bid,
  output logic [NUM_STOCKS-1:0]                  o_req_ready,
  input  logic                                   i_stall,
  input  logic                                   i_flush,
  input  logic [$clog2(NUM_STOCKS)-1:0]          i_flush_stock_id,
  output logic                                   o_mem_valid,
  output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0] o_mem_write_address,
  output logic [$clog2(NUM_STOCKS)-1:0]          o_mem_stock_id,
  output logic [DATA_WIDTH-1:0]                  o_mem_best_ask,
  output logic [DATA_WIDTH-1:0]                  o_mem_best_bid,
  output logic                                   o_tag_valid,
  output logic [$clog2(NUM_STOCKS)-1:0]          o_tag_stock_id,
  output logic                                   o_tag_warm,
  output logic [NUM_STOCKS-1:0]                  o_warm
);

  import vol_pkg::*;

  localparam int SID_W   = $clog2(NUM_STOCKS);
  localparam int MADDR_W = $clog2(NUM_STOCKS * BUFFER_SIZE);
  localparam int PTR_W   = $clog2(BUFFER_SIZE);
  localparam int FILL_W  = $clog2(BUFFER_SIZE + 1);

  function automatic logic [PTR_W-1:0] ptr_wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] f);
    return (f == FILL_W'(BUFFER_SIZE)) ? f : f + 1'b1;
  endfunction

  logic [NUM_STOCKS-1:0] flush_mask;
  logic [NUM_STOCKS-1:0] arb_req;
  logic [NUM_STOCKS-1:0] grant;
  logic [PTR_W-1:0]      ptr_q  [NUM_STOCKS];
  logic [FILL_W-1:0]     fill_q [NUM_STOCKS];

  logic                  vld_p0;
  logic [SID_W-1:0]      id_p0;
  logic [MADDR_W-1:0]    addr_p0;
  logic                  warm_p0;

  logic                  vld_p1;
  logic [SID_W-1:0]      id_p1;
  logic [MADDR_W-1:0]    addr_p1;
  logic [DATA_WIDTH-1:0] ask_p1;
  logic [DATA_WIDTH-1:0] bid_p1;
  logic                  warm_p1;

  tag_t                  tag_p2;

  // ---- p0: arbitration and address formation ----
  always_comb begin
    flush_mask = '0;
    if (i_flush) flush_mask[i_flush_stock_id] = 1'b1;
  end

  // A flushed stock cannot win the same cycle; the clear takes precedence.
  assign arb_req = i_req_valid & ~flush_mask;

  rr_arbiter #(.NUM_REQ(NUM_STOCKS)) u_arb (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_enable      (~i_stall),
    .i_req         (arb_req),
    .o_grant       (grant),
    .o_grant_id    (id_p0),
    .o_grant_valid (vld_p0)
  );

  assign o_req_ready = grant;

  always_comb begin
    addr_p0 = MADDR_W'(int'(id_p0) * BUFFER_SIZE) + MADDR_W'(ptr_q[id_p0]);
    warm_p0 = (fill_sat_inc(fill_q[id_p0]) == FILL_W'(BUFFER_SIZE));
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        ptr_q[s]  <= '0;
        fill_q[s] <= '0;
      end
      o_warm <= '0;
    end else begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        if (flush_mask[s]) begin
          ptr_q[s]  <= '0;
          fill_q[s] <= '0;
        end else if (grant[s]) begin
          ptr_q[s]  <= ptr_wrap_inc(ptr_q[s]);
          fill_q[s] <= fill_sat_inc(fill_q[s]);
        end
        o_warm[s] <= (fill_q[s] == FILL_W'(BUFFER_SIZE));
      end
    end
  end

  // ---- p1: write strobe to the datapath ----
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      vld_p1  <= 1'b0;
      id_p1   <= '0;
      addr_p1 <= '0;
      ask_p1  <= '0;
      bid_p1  <= '0;
      warm_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        id_p1   <= id_p0;
        addr_p1 <= addr_p0;
        ask_p1  <= i_req_ask[id_p0];
        bid_p1  <= i_req_bid[id_p0];
        warm_p1 <= warm_p0;
      end
    end
  end

  assign o_mem_valid         = vld_p1;
  assign o_mem_write_address = addr_p1;
  assign o_mem_stock_id      = id_p1;
  assign o_mem_best_ask      = ask_p1;
  assign o_mem_best_bid      = bid_p1;

  // ---- p2: result tag, aligned with the datapath's output valid ----
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      tag_p2 <= '0;
    end else begin
      tag_p2.valid    <= vld_p1;
      tag_p2.stock_id <= id_p1;
      tag_p2.warm     <= warm_p1 & vld_p1;
    end
  end

  assign o_tag_valid    = tag_p2.valid;
  assign o_tag_stock_id = tag_p2.stock_id;
  assign o_tag_warm     = tag_p2.warm;

endmodule

// File: tb/tb_volatility_scheduler.sv
// Scoreboard bench for volatility_scheduler: directed vectors, expectations queued, monitor compares.
module tb_volatility_scheduler;

  localparam int NS = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NS-1:0]         req_valid, req_ready, warm;
  logic [NS-1:0][DW-1:0] req_ask, req_bid;
  logic                  stall, flush;
  logic [1:0]            flush_id;
  logic                  mem_valid;
  logic [6:0]            mem_addr;
  logic [1:0]            mem_id;
  logic [DW-1:0]         mem_ask, mem_bid;
  logic                  tag_valid;
  logic [1:0]            tag_id;
  logic                  tag_warm;

  volatility_scheduler #(.DATA_WIDTH(DW), .BUFFER_SIZE(20), .NUM_STOCKS(NS)) dut (
    .i_clk               (clk),
    .i_reset_n           (rst_n),
    .i_req_valid         (req_valid),
    .i_req_ask           (req_ask),
    .i_req_bid           (req_bid),
    .o_req_ready         (req_ready),
    .i_stall             (stall),
    .i_flush             (flush),
    .i_flush_stock_id    (flush_id),
    .o_mem_valid         (mem_valid),
    .o_mem_write_address (mem_addr),
    .o_mem_stock_id      (mem_id),
    .o_mem_best_ask      (mem_ask),
    .o_mem_best_bid      (mem_bid),
    .o_tag_valid         (tag_valid),
    .o_tag_stock_id      (tag_id),
    .o_tag_warm          (tag_warm),
    .o_warm              (warm)
  );

  typedef struct {int addr; int id; logic [31:0] ask; logic [31:0] bid;} mem_exp_t;
  typedef struct {int id; logic warm;} tag_exp_t;

  mem_exp_t exp_mem[$];
  tag_exp_t exp_tag[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int t3_addr [8] = '{0, 21, 41, 61, 1, 22, 42, 62};
  int t6_id   [4] = '{2, 3, 0, 1};
  int t6_addr [4] = '{43, 61, 3, 21};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check ready, queue the expected accept, advance past the edge.
  task automatic cyc(input logic [3:0] v, input logic st, input logic fl, input logic [1:0] fid,
                     input logic [3:0] exp_rdy, input int exp_addr, input logic exp_warm,
                     input string nm);
    int id;
    req_valid = v;
    stall     = st;
    flush     = fl;
    flush_id  = fid;
    #1;
    chk(nm, 64'(req_ready), 64'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      id = 0;
      for (int s = 0; s < NS; s++) if (exp_rdy[s]) id = s;
      exp_mem.push_back('{exp_addr, id, req_ask[id], req_bid[id]});
      exp_tag.push_back('{id, exp_warm});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 0, 1'b0, "idle_ready");
  endtask

  always @(negedge clk) begin : monitor
    mem_exp_t me;
    tag_exp_t te;
    if (mem_valid === 1'b1) begin
      if (exp_mem.size() == 0) begin
        chk("unexpected_mem_valid", 64'(mem_valid), 64'd0);
      end else begin
        me = exp_mem.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(me.addr));
        chk("mem_stock", 64'(mem_id), 64'(me.id));
        chk("mem_ask", 64'(mem_ask), 64'(me.ask));
        chk("mem_bid", 64'(mem_bid), 64'(me.bid));
      end
    end
    if (tag_valid === 1'b1) begin
      if (exp_tag.size() == 0) begin
        chk("unexpected_tag_valid", 64'(tag_valid), 64'd0);
      end else begin
        te = exp_tag.pop_front();
        chk("tag_stock", 64'(tag_id), 64'(te.id));
        chk("tag_warm", 64'(tag_warm), 64'(te.warm));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_ask = '0; req_bid = '0;
    stall = 1'b0; flush = 1'b0; flush_id = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_tag_valid", 64'(tag_valid), 64'd0);
    chk("rst_warm", 64'(warm), 64'd0);
    rst_n = 1'b1;

    // Single accept on stock 2
    req_ask[2] = 32'd200; req_bid[2] = 32'd100;
    cyc(4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100, 40, 1'b0, "t1_ready");
    idle(2);

    // Fill stock 1's window and wrap its pointer
    for (int i = 0; i < 21; i++) begin
      req_ask[1] = 32'(1000 + i);
      req_bid[1] = 32'(900 + i);
      if (i == 19) chk("t2_warm_before_full", 64'(warm), 64'd0);
      cyc(4'b0010, 1'b0, 1'b0, 2'd0, 4'b0010, 20 + (i % 20), (i >= 19), "t2_ready");
    end
    idle(1);
    chk("t2_warm_set", 64'(warm), 64'b0010);

    // Round-robin with every stock requesting
    for (int s = 0; s < NS; s++) begin
      req_ask[s] = 32'(s * 16 + 5);
      req_bid[s] = 32'(s * 16 + 3);
    end
    cyc(4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 60, 1'b0, "t3_pre_ready");
    for (int i = 0; i < 8; i++)
      cyc(4'b1111, 1'b0, 1'b0, 2'd0, oh[i % 4], t3_addr[i], ((i % 4) == 1), "t3_rr_ready");

    // Stall blocks all grants and keeps the priority pointer
    cyc(4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 0, 1'b0, "t4_stall_ready");
    cyc(4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 0, 1'b0, "t4_stall_ready");
    cyc(4'b1111, 1'b0, 1'b0, 2'd0, 4'b0001, 2, 1'b0, "t4_resume_ready");
    idle(1);

    // Flush interactions
    cyc(4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 63, 1'b0, "t5_s3_ready");
    cyc(4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 64, 1'b0, "t5_s3_ready");
    cyc(4'b1000, 1'b0, 1'b1, 2'd3, 4'b0000, 0, 1'b0, "t5_flush_only_ready");
    cyc(4'b1010, 1'b0, 1'b1, 2'd3, 4'b0010, 23, 1'b1, "t5_flush_other_ready");
    cyc(4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 60, 1'b0, "t5_after_flush_ready");
    chk("t5_warm", 64'(warm), 64'b0010);
    cyc(4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000, 0, 1'b0, "t5_flush_stalled_ready");
    chk("t5_warm_lag", 64'(warm), 64'b0010);
    idle(1);
    chk("t5_warm_drop", 64'(warm), 64'b0000);
    cyc(4'b0010, 1'b0, 1'b0, 2'd0, 4'b0010, 20, 1'b0, "t5_s1_restart_ready");

    // Reset in the middle of continuous traffic
    for (int i = 0; i < 4; i++)
      cyc(4'b1111, 1'b0, 1'b0, 2'd0, oh[t6_id[i]], t6_addr[i], 1'b0, "t6_traffic_ready");
    rst_n = 1'b0;
    void'(exp_tag.pop_back());
    @(posedge clk);
    #1;
    chk("t6_rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("t6_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("t6_rst_mem_stock", 64'(mem_id), 64'd0);
    chk("t6_rst_mem_ask", 64'(mem_ask), 64'd0);
    chk("t6_rst_mem_bid", 64'(mem_bid), 64'd0);
    chk("t6_rst_tag_valid", 64'(tag_valid), 64'd0);
    chk("t6_rst_tag_stock", 64'(tag_id), 64'd0);
    chk("t6_rst_tag_warm", 64'(tag_warm), 64'd0);
    chk("t6_rst_warm", 64'(warm), 64'd0);
    rst_n = 1'b1;
    cyc(4'b1111, 1'b0, 1'b0, 2'd0, 4'b0001, 0, 1'b0, "t6_post_rst_ready");
    idle(3);

    chk("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
    chk("tag_queue_drained", 64'(exp_tag.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
